uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 4-entry byte FIFO feeding an 8-bit UART transmitter (optional parity, 1 or 2 stop bits).
// Latency: byte accepted on edge E0 into an empty FIFO while idle -> start bit on tx after edge E0+1.
// Backpressure: in_ready low only when the FIFO holds 4 bytes or rst_n is low; frames are never aborted.

// Small 4-deep FIFO with registered occupancy; storage is left unreset.
module uart_tx_fifo #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdat_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdat_o,
    output logic          full_o,
    output logic [2:0]    count_o
);
    logic [DW-1:0] mem_q [4];
    logic [1:0]    wr_ptr_q;
    logic [1:0]    rd_ptr_q;
    logic [2:0]    count_q;
    logic [2:0]    count_d;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO ignores pushes and an empty one ignores pops, so nothing is overwritten.
    assign push_ok = push_i && (count_q != 3'd4);
    assign pop_ok  = pop_i && (count_q != 3'd0);

    // Occupancy follows the push/pop pair; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 3'd1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 3'd1;
        end
    end

    // Pointer and occupancy registers; 2-bit pointers wrap 3->0 on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_d;
        end
    end

    // Data storage; contents are meaningless until written so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdat_i;
    end

    assign rdat_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 3'd4);
    assign count_o = count_q;
endmodule

// uart_tx: 4-entry byte FIFO feeding an 8-bit UART transmitter (optional parity, 1 or 2 stop bits).
// Latency: byte accepted on edge E0 into an empty FIFO while idle -> start bit on tx after edge E0+1.
// Backpressure: in_ready low only when the FIFO holds 4 bytes or rst_n is low; frames are never aborted.
module uart_tx #(
    parameter int unsigned CLK_PER_BIT = 16,
    parameter bit          PARITY_EN   = 1'b0,
    parameter bit          PARITY_ODD  = 1'b0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fifo_count
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);
    localparam bit          TWO_STOP  = (STOP_BITS == 2);

    state_e      state_q, state_d;
    logic [15:0] baud_q,  baud_d;
    logic [2:0]  bit_q,   bit_d;
    logic        stop_q,  stop_d;   // set while sending the second stop bit
    logic [7:0]  shift_q, shift_d;
    logic        tx_q,    tx_d;
    logic        busy_q,  busy_d;

    logic        push;
    logic        pop;
    logic        full;
    logic [7:0]  head;
    logic [2:0]  count;
    logic        have_data;
    logic        bit_end;

    assign in_ready  = rst_n && !full;
    assign push      = in_valid && in_ready;
    assign have_data = (count != 3'd0);
    assign bit_end   = (baud_q == BAUD_LAST);

    uart_tx_fifo #(.DW(8)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdat_i  (data_in),
        .pop_i   (pop),
        .rdat_o  (head),
        .full_o  (full),
        .count_o (count)
    );

    // State register: FSM, bit timing counters, byte under transmission and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: advance through the frame at each bit boundary, chaining frames without gaps.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                if (have_data) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        stop_d  = 1'b0;
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = 16'd0;
                    if (TWO_STOP && !stop_q) begin
                        stop_d = 1'b1;
                    end else if (have_data) begin
                        pop     = 1'b1;
                        shift_d = head;
                        stop_d  = 1'b0;
                        state_d = S_START;
                    end else begin
                        stop_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: line level for the state being entered, so tx changes on the same edge as the FSM.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[bit_d];
            S_PARITY: tx_d = (^shift_d) ^ PARITY_ODD;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives a default uart_tx and a parity/two-stop variant from shared inputs.
// Each line is decoded by a bit-sampling receiver and matched against the bytes each instance accepted.
// Directed cases cover reset, timing, back-to-back frames and mid-frame reset; then a random stream.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       in_valid;
    logic       rdy0, tx0, busy0;
    logic [2:0] cnt0;
    logic       rdy1, tx1, busy1;
    logic [2:0] cnt1;

    uart_tx dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
        .in_ready(rdy0), .tx(tx0), .busy(busy0), .fifo_count(cnt0)
    );

    uart_tx #(.CLK_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
        .in_ready(rdy1), .tx(tx1), .busy(busy1), .fifo_count(cnt1)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  expq0[$];
    logic [7:0]  expq1[$];
    int          rx_cnt[2] = '{0, 0};
    bit          mon_on = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit k of a frame for byte b: start, 8 data LSB first, optional parity, then stop ones.
    function automatic logic frame_bit(input logic [7:0] b, input bit pen, input bit podd, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (pen && k == 9) return 1'(($countones(b) + int'(podd)) % 2);
        return 1'b1;
    endfunction

    function automatic logic txw(input int w);
        return (w == 0) ? tx0 : tx1;
    endfunction

    // Accepted bytes are recorded mid-cycle, ahead of the edge that takes them; reset flushes all.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq0.delete();
            expq1.delete();
        end else begin
            if (in_valid && rdy0) expq0.push_back(data_in);
            if (in_valid && rdy1) expq1.push_back(data_in);
        end
    end

    // Receiver: find the start bit, sample each bit near its middle, compare with the oldest accepted byte.
    task automatic rx_mon(input int w);
        bit         pen;
        int         nbits;
        logic       line [12];
        logic [7:0] got;
        logic [7:0] exp;
        int         bad;
        int         qs;
        pen   = (w == 1);
        nbits = (w == 1) ? 12 : 10;
        forever begin
            @(negedge clk);
            if (mon_on && rst_n && txw(w) == 1'b0) begin
                repeat (7) @(negedge clk);
                for (int k = 0; k < nbits; k++) begin
                    if (k != 0) repeat (16) @(negedge clk);
                    line[k] = txw(w);
                end
                for (int k = 0; k < 8; k++) got[k] = line[k+1];
                qs = (w == 0) ? expq0.size() : expq1.size();
                chk($sformatf("rx%0d_queued", w), 32'(qs > 0), 32'd1);
                if (qs > 0) begin
                    exp = (w == 0) ? expq0.pop_front() : expq1.pop_front();
                    chk($sformatf("rx%0d_byte", w), 32'(got), 32'(exp));
                    bad = 0;
                    for (int k = 0; k < nbits; k++) begin
                        if ((k == 0 || k > 8) && line[k] !== frame_bit(exp, pen, pen, k)) bad++;
                    end
                    chk($sformatf("rx%0d_framing", w), bad, 0);
                    rx_cnt[w]++;
                end
            end
        end
    endtask

    initial rx_mon(0);
    initial rx_mon(1);

    initial begin
        int  bad;
        int  n;
        int  cyc;
        int  i;
        int  gap;
        int  base0;
        bit  acc;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = 8'h00;

        // Reset: in_ready low while held, then idle outputs after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_reset", rdy0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_count", cnt0, 3'd0);
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_tx_p", tx1, 1'b1);

        // Single byte 0xA5: one-cycle start latency, exact 160-cycle line shape, busy drop.
        @(posedge clk); #1 data_in = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("a5_count_after_accept", cnt0, 3'd1);
        chk("a5_tx_before_start", tx0, 1'b1);
        @(negedge clk);
        chk("a5_start_latency", tx0, 1'b0);
        chk("a5_busy", busy0, 1'b1);
        chk("a5_popped", cnt0, 3'd0);
        bad = 0;
        for (int c = 0; c < 160; c++) begin
            if (c != 0) @(negedge clk);
            if (tx0 !== frame_bit(8'hA5, 1'b0, 1'b0, c / 16)) bad++;
            if (busy0 !== 1'b1) bad++;
        end
        chk("a5_line_cycles", bad, 0);
        @(negedge clk);
        chk("a5_busy_drop", busy0, 1'b0);
        chk("a5_idle_tx", tx0, 1'b1);
        n = 0;
        while (busy1 && n < 400) begin n++; @(negedge clk); end
        chk("p_frame_len", 160 + n, 192);

        // Five bytes back-to-back with in_valid held.
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        i = 0; cyc = 0; in_valid = 1'b1; data_in = 8'h01;
        while (i < 5 && cyc < 50) begin
            @(negedge clk);
            if (cnt0 == 3'd4) chk("b2b_full_not_ready", rdy0, 1'b0);
            acc = rdy0;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin i++; data_in = 8'(i + 1); end
            if (i == 5) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("b2b_all_accepted", i, 5);
        chk("b2b_accept_cycles", cyc, 5);
        @(negedge clk);
        chk("b2b_full_count", cnt0, 3'd4);
        chk("b2b_full_ready", rdy0, 1'b0);
        base0 = rx_cnt[0];
        n = 0;
        while (busy0 && n < 2000) begin n++; @(negedge clk); end
        chk("b2b_busy_span", n + 3, 800);
        chk("b2b_frames", rx_cnt[0] - base0, 5);
        n = 0;
        while (busy1 && n < 3000) begin n++; @(negedge clk); end
        chk("b2b_p_drained", busy1, 1'b0);

        // Reset during data bit 3 of 0x5A with two bytes queued.
        mon_on = 1'b0;
        @(posedge clk); #1 in_valid = 1'b1; data_in = 8'h5A;
        @(posedge clk); #1 data_in = 8'h11;
        @(posedge clk); #1 data_in = 8'h22;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (68) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_low", rdy0, 1'b0);
        chk("mid_rst_queued", cnt0, 3'd2);
        chk("mid_rst_busy_before", busy0, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", tx0, 1'b1);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_count", cnt0, 3'd0);
        chk("mid_rst_busy_p", busy1, 1'b0);
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        chk("mid_rst_silent", bad, 0);
        mon_on = 1'b1;

        // Random stream of 256 bytes with random gaps, checked through the receivers.
        base0 = rx_cnt[0];
        @(posedge clk); #1;
        for (int k = 0; k < 256; k++) begin
            data_in  = 8'($urandom);
            in_valid = 1'b1;
            cyc = 0;
            do begin
                @(negedge clk);
                acc = rdy0;
                @(posedge clk); #1;
                cyc++;
            end while (!acc && cyc < 1000);
            if (!acc) chk("rnd_accept_timeout", acc, 1'b1);
            in_valid = 1'b0;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 200) : 0;
            repeat (gap) @(posedge clk);
            #1;
        end
        n = 0;
        while ((expq0.size() != 0 || expq1.size() != 0 || busy0 || busy1) && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("rnd_frames0", rx_cnt[0] - base0, 256);
        chk("rnd_left0", expq0.size(), 0);
        chk("rnd_left1", expq1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
